rc4_prga_engine: RTL and testbench

Parametrised RC4 pseudo-random generation (PRGA) engine: a sequencer with its own datapath for the i/j/S-swap keystream loop, the XOR with ciphertext and the plaintext write-back. Message length is set at run time, the block can abort, and it can optionally reject a candidate key early by checking each output byte against a character window. It sits after the S-box init/key-schedule stage and drives the shared S memory, the ciphertext ROM and the plaintext RAM. A key-search controller or a single-key top level starts it and collects the pass/fail verdict.

---
 rtl/rc4_prga_engine.sv | 156 +++++++++++++++
 tb/tb_rc4_prga_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA sequencer: keystream generation, S swap, XOR with ciphertext and plaintext write-back.
// Latency 10 cycles per byte plus one DONE cycle; no backpressure, abort returns to IDLE next cycle.
module rc4_prga_engine #(
    parameter int LEN_W    = 5,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [7:0]       chk_lo,
    input  logic [7:0]       chk_hi,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren,
    input  logic [7:0]       s_q,
    output logic [LEN_W-1:0] enc_addr,
    input  logic [7:0]       enc_q,
    output logic [LEN_W-1:0] dec_addr,
    output logic [7:0]       dec_wrdata,
    output logic             dec_wren,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] bytes_done
);

    typedef enum logic [3:0] {
        IDLE, INC_I, RD_SI, LAT_SI, RD_SJ, LAT_SJ, WR_SI,
        RD_F, LAT_F, WR_DEC, NEXT, DONE
    } state_t;

    state_t           state;
    logic [7:0]       i, j, si, sj, f, enc;
    logic [LEN_W-1:0] k, len_q;
    logic [7:0]       lo_q, hi_q;
    logic             mode_q, fail;
    logic [LEN_W-1:0] len_m1;
    logic             in_window;

    assign busy       = (state != IDLE);
    assign enc_addr   = k;
    assign dec_addr   = k;
    assign dec_wrdata = mode_q ? f : (f ^ enc);
    assign len_m1     = len_q - LEN_W'(1);
    assign in_window  = ((dec_wrdata >= lo_q) && (dec_wrdata <= hi_q)) || (dec_wrdata == 8'h20);

    // Memory-facing strobes are registered: each is set on the edge entering the state that owns it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            i          <= 8'd0;
            j          <= 8'd0;
            si         <= 8'd0;
            sj         <= 8'd0;
            f          <= 8'd0;
            enc        <= 8'd0;
            k          <= '0;
            len_q      <= '0;
            lo_q       <= 8'd0;
            hi_q       <= 8'd0;
            mode_q     <= 1'b0;
            fail       <= 1'b0;
            s_addr     <= 8'd0;
            s_wrdata   <= 8'd0;
            s_wren     <= 1'b0;
            dec_wren   <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            bytes_done <= '0;
        end else begin
            s_wren   <= 1'b0;
            dec_wren <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        i          <= 8'd0;
                        j          <= 8'd0;
                        k          <= '0;
                        mode_q     <= mode;
                        len_q      <= msg_len;
                        lo_q       <= chk_lo;
                        hi_q       <= chk_hi;
                        fail       <= 1'b0;
                        bytes_done <= '0;
                        pass       <= (msg_len == '0);
                        if (msg_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= INC_I;
                        end
                    end
                    INC_I: begin
                        i      <= i + 8'd1;
                        s_addr <= i + 8'd1;
                        state  <= RD_SI;
                    end
                    RD_SI: state <= LAT_SI;
                    LAT_SI: begin
                        si     <= s_q;
                        j      <= j + s_q;
                        s_addr <= j + s_q;
                        state  <= RD_SJ;
                    end
                    RD_SJ: begin
                        s_wrdata <= si;
                        s_wren   <= 1'b1;
                        state    <= LAT_SJ;
                    end
                    LAT_SJ: begin
                        sj       <= s_q;
                        s_addr   <= i;
                        s_wrdata <= s_q;
                        s_wren   <= 1'b1;
                        state    <= WR_SI;
                    end
                    WR_SI: begin
                        s_addr <= si + sj;
                        state  <= RD_F;
                    end
                    RD_F: state <= LAT_F;
                    LAT_F: begin
                        f        <= s_q;
                        enc      <= enc_q;
                        dec_wren <= 1'b1;
                        state    <= WR_DEC;
                    end
                    WR_DEC: begin
                        fail  <= CHECK_EN && !in_window;
                        state <= NEXT;
                    end
                    NEXT: begin
                        k          <= k + LEN_W'(1);
                        bytes_done <= k + LEN_W'(1);
                        if (fail || (k == len_m1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= !fail;
                        end else begin
                            state <= INC_I;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Bench for rc4_prga_engine: memory models, a plain RC4 reference, a write monitor and directed runs.
module tb_rc4_prga_engine;

    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst_n, start, abort, mode;
    logic [LEN_W-1:0] msg_len;
    logic [7:0]       chk_lo, chk_hi;
    logic [7:0]       s_addr, s_wrdata, s_q;
    logic             s_wren;
    logic [LEN_W-1:0] enc_addr, dec_addr, bytes_done;
    logic [7:0]       enc_q, dec_wrdata;
    logic             dec_wren, busy, done, pass;

    rc4_prga_engine #(.LEN_W(LEN_W), .CHECK_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .msg_len(msg_len), .chk_lo(chk_lo), .chk_hi(chk_hi),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_q(s_q),
        .enc_addr(enc_addr), .enc_q(enc_q),
        .dec_addr(dec_addr), .dec_wrdata(dec_wrdata), .dec_wren(dec_wren),
        .busy(busy), .done(done), .pass(pass), .bytes_done(bytes_done)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem[256], s_init[256], m_s[256];
    logic [7:0] enc_mem[32], enc_init[32], dec_mem[32], exp_dec[32];
    logic       load = 1'b0;
    int         exp_n, n_s_wr, n_dec_wr;
    bit         exp_pass;
    int         checks = 0, errors = 0;

    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
            for (int x = 0; x < 32; x++) begin
                enc_mem[x] <= enc_init[x];
                dec_mem[x] <= 8'hEE;
            end
        end else begin
            s_q   <= s_mem[s_addr];
            enc_q <= enc_mem[enc_addr];
            if (s_wren)   s_mem[s_addr]     <= s_wrdata;
            if (dec_wren) dec_mem[dec_addr] <= dec_wrdata;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every plaintext write is compared against the reference as it happens.
    always @(negedge clk) begin
        if (rst_n && s_wren) n_s_wr++;
        if (rst_n && dec_wren) begin
            n_dec_wr++;
            chk("dec_addr_range", 64'(int'(dec_addr) < exp_n), 64'd1);
            chk("dec_wrdata", {56'd0, dec_wrdata}, {56'd0, exp_dec[dec_addr]});
        end
    end

    task automatic prep(input int len, input bit md, input logic [7:0] lo, input logic [7:0] hi);
        logic [7:0] mi, mj, t, f, b;
        for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
        mi = 0; mj = 0; exp_n = 0; exp_pass = 1'b1;
        for (int x = 0; x < 32; x++) exp_dec[x] = 8'hEE;
        for (int n = 0; n < len; n++) begin
            mi = mi + 8'd1;
            mj = mj + m_s[mi];
            t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
            f = m_s[8'(m_s[mi] + m_s[mj])];
            b = md ? f : (f ^ enc_init[n]);
            exp_dec[n] = b;
            exp_n = n + 1;
            if (!(((b >= lo) && (b <= hi)) || (b == 8'h20))) begin
                exp_pass = 1'b0;
                break;
            end
        end
        mode = md; msg_len = LEN_W'(len); chk_lo = lo; chk_hi = hi;
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Start at the next edge ("edge 0"); cyc numbers cycles so that cycle 1 follows edge 0.
    task automatic go(input bit extra, output int cyc);
        int bad;
        n_s_wr = 0; n_dec_wr = 0;
        start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (!done && cyc < 1000) begin
            start = extra && (cyc == 3);
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        chk("done_cycle", 64'(cyc), 64'(10 * exp_n + 1));
        chk("pass", {63'd0, pass}, {63'd0, exp_pass});
        chk("bytes_done", {59'd0, bytes_done}, 64'(exp_n));
        if (extra) start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("done_pulse_idle", {62'd0, done, busy}, 64'd0);
        chk("dec_write_count", 64'(n_dec_wr), 64'(exp_n));
        chk("s_write_count", 64'(n_s_wr), 64'(2 * exp_n));
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
        chk("s_final", 64'(bad), 64'd0);
        bad = 0;
        for (int x = 0; x < 32; x++) if (dec_mem[x] !== exp_dec[x]) bad++;
        chk("dec_final", 64'(bad), 64'd0);
    endtask

    task automatic ident_zero();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 0; x < 32; x++) enc_init[x] = 8'h00;
    endtask

    function automatic logic [63:0] all_outs();
        return {20'd0, s_addr, s_wrdata, s_wren, enc_addr, dec_addr, dec_wrdata,
                dec_wren, busy, done, pass, bytes_done};
    endfunction

    initial begin
        int cyc, seen;
        logic [7:0] t;
        int r;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
        msg_len = '0; chk_lo = 8'h00; chk_hi = 8'hFF;
        exp_n = 0; n_s_wr = 0; n_dec_wr = 0;
        ident_zero();
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;

        // Single byte on identity S: i=j=1, keystream S[2]=2.
        prep(1, 1'b0, 8'h00, 8'hFF);
        go(1'b0, cyc);
        chk("lit_len1_cycle", 64'(cyc), 64'd11);
        chk("lit_dec0", {56'd0, dec_mem[0]}, 64'h02);
        chk("lit_s1", {56'd0, s_mem[1]}, 64'h01);
        chk("lit_len1_pass", {63'd0, pass}, 64'd1);

        prep(2, 1'b0, 8'h00, 8'hFF);
        go(1'b0, cyc);
        chk("lit_len2_cycle", 64'(cyc), 64'd21);
        chk("lit_dec1", {56'd0, dec_mem[1]}, 64'h05);
        chk("lit_s2", {56'd0, s_mem[2]}, 64'h03);
        chk("lit_s3", {56'd0, s_mem[3]}, 64'h02);

        enc_init[0] = 8'h63; enc_init[1] = 8'h66;
        prep(2, 1'b0, 8'h61, 8'h7A);
        go(1'b0, cyc);
        chk("lit_txt0", {56'd0, dec_mem[0]}, 64'h61);
        chk("lit_txt1", {56'd0, dec_mem[1]}, 64'h63);
        chk("lit_txt_pass", {63'd0, pass}, 64'd1);

        // Early reject: first byte 0x02 lies outside 'a'..'z'.
        ident_zero();
        prep(5, 1'b0, 8'h61, 8'h7A);
        go(1'b0, cyc);
        chk("lit_early_cycle", 64'(cyc), 64'd11);
        chk("lit_early_pass", {63'd0, pass}, 64'd0);
        chk("lit_early_bytes", {59'd0, bytes_done}, 64'd1);
        chk("lit_early_dec1", {56'd0, dec_mem[1]}, 64'hEE);

        // Abort in cycle 4, restart in cycle 6 with a stray start mid-run and in DONE.
        prep(3, 1'b0, 8'h00, 8'hFF);
        n_dec_wr = 0; n_s_wr = 0; seen = 0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (done) seen++;
            abort = (c == 4);
            @(negedge clk);
        end
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_no_done", 64'(seen + int'(done)), 64'd0);
        chk("abort_no_writes", 64'(n_dec_wr + n_s_wr), 64'd0);
        go(1'b1, cyc);

        ident_zero();
        prep(0, 1'b1, 8'h00, 8'hFF);
        go(1'b0, cyc);
        chk("lit_len0_cycle", 64'(cyc), 64'd1);
        chk("lit_len0_pass", {63'd0, pass}, 64'd1);

        // Shuffled S and random ciphertext, both modes.
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
        end
        for (int x = 0; x < 32; x++) enc_init[x] = 8'($urandom);
        prep(31, 1'b0, 8'h00, 8'hFF);
        go(1'b0, cyc);
        prep(17, 1'b1, 8'h00, 8'h7E);
        go(1'b0, cyc);
        prep(9, 1'b0, 8'h10, 8'hF0);
        go(1'b0, cyc);

        // Reset in the cycle S is being written.
        prep(4, 1'b0, 8'h00, 8'hFF);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_s_wren", {63'd0, s_wren}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        prep(4, 1'b0, 8'h00, 8'hFF);
        go(1'b0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
